// File: rtl/type_rule_cfg_writer.sv
// Builds type_rule_t records from a 32-bit cfg word stream and drives the rule table write port.
// Optional read-back shadow of the rule table is enabled by defining TYPE_RULE_SHADOW_EN.
package parser_pkg;
    typedef struct packed {
        logic        typeRule_valid;
        logic [15:0] key_value;
        logic [15:0] key_mask;
        logic [7:0]  next_type;
        logic [7:0]  hdr_len;
    } type_rule_t;
endpackage

module type_rule_cfg_writer
    import parser_pkg::*;
#(
    parameter int IDX_W    = 8,
    parameter int RULE_NUM = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cfg_valid,
    output logic                o_cfg_ready,
    input  logic [31:0]         i_cfg_data,
    input  logic                i_cfg_last,
    output logic [RULE_NUM-1:0] o_rule_wren,
    output type_rule_t          o_type_rule,
    output logic                o_busy,
`ifdef TYPE_RULE_SHADOW_EN
    output logic                o_rd_valid,
    input  logic                i_rd_ready,
    output logic [31:0]         o_rd_data,
    output logic                o_rd_last,
`endif
    output logic                o_err
);

    localparam int CFG_W  = 32;
    localparam int RULE_W = $bits(type_rule_t);
    localparam int WORDS  = (RULE_W + CFG_W - 1) / CFG_W;
    localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CLR_W  = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;

    localparam logic [CNT_W-1:0]    LAST_WORD  = CNT_W'(WORDS - 1);
    localparam logic [CLR_W-1:0]    LAST_RULE  = CLR_W'(RULE_NUM - 1);
    localparam logic [IDX_W:0]      RULE_NUM_W = (IDX_W + 1)'(RULE_NUM);
    localparam logic [RULE_NUM-1:0] ONE_HOT0   = RULE_NUM'(1);

    localparam logic [3:0] OP_WRITE  = 4'd1;
    localparam logic [3:0] OP_INVAL  = 4'd2;
    localparam logic [3:0] OP_CLRALL = 4'd3;
`ifdef TYPE_RULE_SHADOW_EN
    localparam logic [3:0] OP_READ   = 4'd4;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DRAIN,
        ST_COMMIT,
        ST_CLEAR,
        ST_RD_FETCH,
        ST_RD_STREAM
    } state_t;

    state_t                   state_reg;
    logic [CNT_W-1:0]         wcnt_reg;
    logic [CLR_W-1:0]         clr_cnt_reg;
    logic [IDX_W-1:0]         idx_reg;
    logic                     idx_bad_reg;
    logic [WORDS*CFG_W-1:0]   payload_reg;
    logic [RULE_NUM-1:0]      wren_reg;
    type_rule_t               rule_reg;
    logic                     err_reg;

    logic                     cfg_ready;
    logic                     cfg_fire;
    logic [3:0]               hdr_op;
    logic [IDX_W-1:0]         hdr_idx;
    logic                     hdr_idx_bad;
    logic [WORDS*CFG_W-1:0]   asm_vec;

    assign cfg_ready   = (state_reg == ST_IDLE) || (state_reg == ST_COLLECT) ||
                         (state_reg == ST_DRAIN);
    assign cfg_fire    = i_cfg_valid && cfg_ready;
    assign hdr_op      = i_cfg_data[31:28];
    assign hdr_idx     = i_cfg_data[IDX_W-1:0];
    assign hdr_idx_bad = ({1'b0, hdr_idx} >= RULE_NUM_W);

    // Incoming word is spliced into its slot so the final word can commit on the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_asm
            assign asm_vec[gi*CFG_W +: CFG_W] = (wcnt_reg == CNT_W'(gi)) ? i_cfg_data
                                              : payload_reg[gi*CFG_W +: CFG_W];
        end
    endgenerate

`ifdef TYPE_RULE_SHADOW_EN
    type_rule_t               shadow_mem [RULE_NUM];
    logic [RULE_NUM-1:0]      shadow_vld_reg;
    type_rule_t               rd_rule_reg;
    logic                     rd_hit_reg;
    logic                     rd_valid_reg;
    logic [CNT_W-1:0]         rd_cnt_reg;
    logic                     shadow_we;
    logic [CLR_W-1:0]         shadow_waddr;
    logic [WORDS*CFG_W-1:0]   rd_pad;
    logic [CFG_W-1:0]         rd_words [WORDS];

    assign shadow_we    = ((state_reg == ST_COMMIT) && (|wren_reg)) || (state_reg == ST_CLEAR);
    assign shadow_waddr = (state_reg == ST_CLEAR) ? clr_cnt_reg : idx_reg[CLR_W-1:0];

    // RAM body carries no reset; the valid vector makes never-written entries read as zero.
    always_ff @(posedge i_clk) begin
        if (shadow_we) begin
            shadow_mem[shadow_waddr] <= rule_reg;
        end
        if (state_reg == ST_RD_FETCH) begin
            rd_rule_reg <= shadow_mem[idx_reg[CLR_W-1:0]];
        end
    end

    always_comb begin
        rd_pad = '0;
        if (rd_hit_reg) begin
            rd_pad[RULE_W-1:0] = rd_rule_reg;
        end
    end

    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_rd
            assign rd_words[gi] = rd_pad[gi*CFG_W +: CFG_W];
        end
    endgenerate

    assign o_rd_valid = rd_valid_reg;
    assign o_rd_data  = rd_words[rd_cnt_reg];
    assign o_rd_last  = rd_valid_reg && (rd_cnt_reg == LAST_WORD);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            wcnt_reg    <= '0;
            clr_cnt_reg <= '0;
            idx_reg     <= '0;
            idx_bad_reg <= 1'b0;
            payload_reg <= '0;
            wren_reg    <= '0;
            rule_reg    <= '0;
            err_reg     <= 1'b0;
`ifdef TYPE_RULE_SHADOW_EN
            shadow_vld_reg <= '0;
            rd_hit_reg     <= 1'b0;
            rd_valid_reg   <= 1'b0;
            rd_cnt_reg     <= '0;
`endif
        end else begin
            wren_reg <= '0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_fire) begin
                        idx_reg     <= hdr_idx;
                        idx_bad_reg <= hdr_idx_bad;
                        wcnt_reg    <= '0;
                        case (hdr_op)
                            OP_WRITE: begin
                                if (i_cfg_last) begin
                                    err_reg <= 1'b1;
                                end else begin
                                    state_reg <= ST_COLLECT;
                                end
                            end
                            OP_INVAL: begin
                                if (!i_cfg_last) begin
                                    state_reg <= ST_DRAIN;
                                end else if (hdr_idx_bad) begin
                                    err_reg <= 1'b1;
                                end else begin
                                    state_reg <= ST_COMMIT;
                                    wren_reg  <= ONE_HOT0 << hdr_idx;
                                    rule_reg  <= '0;
                                end
                            end
                            OP_CLRALL: begin
                                if (!i_cfg_last) begin
                                    state_reg <= ST_DRAIN;
                                end else begin
                                    state_reg   <= ST_CLEAR;
                                    clr_cnt_reg <= '0;
                                    wren_reg    <= ONE_HOT0;
                                    rule_reg    <= '0;
                                end
                            end
`ifdef TYPE_RULE_SHADOW_EN
                            OP_READ: begin
                                if (!i_cfg_last) begin
                                    state_reg <= ST_DRAIN;
                                end else if (hdr_idx_bad) begin
                                    err_reg <= 1'b1;
                                end else begin
                                    state_reg <= ST_RD_FETCH;
                                end
                            end
`endif
                            default: err_reg <= 1'b1;
                        endcase
                    end
                end
                ST_COLLECT: begin
                    if (cfg_fire) begin
                        payload_reg <= asm_vec;
                        if (wcnt_reg == LAST_WORD) begin
                            if (!i_cfg_last) begin
                                state_reg <= ST_DRAIN;
                            end else if (idx_bad_reg) begin
                                state_reg <= ST_IDLE;
                                err_reg   <= 1'b1;
                            end else begin
                                state_reg <= ST_COMMIT;
                                wren_reg  <= ONE_HOT0 << idx_reg;
                                rule_reg  <= asm_vec[RULE_W-1:0];
                            end
                        end else if (i_cfg_last) begin
                            state_reg <= ST_IDLE;
                            err_reg   <= 1'b1;
                        end else begin
                            wcnt_reg <= wcnt_reg + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (cfg_fire && i_cfg_last) begin
                        state_reg <= ST_IDLE;
                        err_reg   <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state_reg <= ST_IDLE;
                end
                // The closing COMMIT pass (no strobe) keeps ready low one cycle past the sweep.
                ST_CLEAR: begin
                    if (clr_cnt_reg == LAST_RULE) begin
                        state_reg <= ST_COMMIT;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                        wren_reg    <= wren_reg << 1;
                    end
                end
`ifdef TYPE_RULE_SHADOW_EN
                ST_RD_FETCH: begin
                    rd_hit_reg   <= shadow_vld_reg[idx_reg[CLR_W-1:0]];
                    rd_valid_reg <= 1'b1;
                    rd_cnt_reg   <= '0;
                    state_reg    <= ST_RD_STREAM;
                end
                ST_RD_STREAM: begin
                    if (i_rd_ready) begin
                        if (rd_cnt_reg == LAST_WORD) begin
                            rd_valid_reg <= 1'b0;
                            state_reg    <= ST_IDLE;
                        end else begin
                            rd_cnt_reg <= rd_cnt_reg + 1'b1;
                        end
                    end
                end
`endif
                default: state_reg <= ST_IDLE;
            endcase
`ifdef TYPE_RULE_SHADOW_EN
            if (shadow_we) begin
                shadow_vld_reg[shadow_waddr] <= 1'b1;
            end
`endif
        end
    end

    assign o_cfg_ready = cfg_ready;
    assign o_rule_wren = wren_reg;
    assign o_type_rule = rule_reg;
    assign o_busy      = (state_reg != ST_IDLE);
    assign o_err       = err_reg;

endmodule

// File: tb/tb_type_rule_cfg_writer.sv
// Directed bench for type_rule_cfg_writer: command vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_type_rule_cfg_writer;
    import parser_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;
    logic        cfg_last;
    logic [15:0] rule_wren;
    type_rule_t  type_rule;
    logic        busy;
    logic        err;
`ifdef TYPE_RULE_SHADOW_EN
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_last;
`endif

    always #5 clk = ~clk;

    type_rule_cfg_writer #(.IDX_W(8), .RULE_NUM(16)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_data  (cfg_data),
        .i_cfg_last  (cfg_last),
        .o_rule_wren (rule_wren),
        .o_type_rule (type_rule),
        .o_busy      (busy),
`ifdef TYPE_RULE_SHADOW_EN
        .o_rd_valid  (rd_valid),
        .i_rd_ready  (rd_ready),
        .o_rd_data   (rd_data),
        .o_rd_last   (rd_last),
`endif
        .o_err       (err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wren_pulses = 0;
    int err_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (|rule_wren) wren_pulses <= wren_pulses + 1;
        if (err === 1'b1) err_pulses <= err_pulses + 1;
    end

    typedef struct {
        logic [31:0] w0, w1, w2, w3;
        int          n;
        logic [15:0] exp_wren;
        logic [48:0] exp_rule;
        bit          exp_err;
    } vec_t;

    vec_t        vecs [14];
    int          n_vec;
    logic [31:0] vw [4];
    int          wp0, ep0, acc_cyc, a0, a1, low, bad, guard;
    logic [15:0] exp_oh;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, output int acc);
        int g;
        g = 0;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = l;
        while (cfg_ready !== 1'b1 && g < 64) begin
            @(negedge clk);
            g++;
        end
        acc = cyc;
        if (g >= 64) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: cfg_ready stayed 0, required 1");
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // {hdr, w1, w2, w3, words, wren, rule, err}
        vecs[0]  = '{32'h1000_0003, 32'hA5A5_0001, 32'hA5A5_0002, 32'h0, 3, 16'h0008, 49'h1_0002_A5A5_0001, 1'b0};
        vecs[1]  = '{32'h2000_0000, 32'h0, 32'h0, 32'h0, 1, 16'h0001, 49'h0, 1'b0};
        vecs[2]  = '{32'h1000_000F, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 3, 16'h8000, 49'h1_FFFF_1234_5678, 1'b0};
        vecs[3]  = '{32'h1000_0010, 32'h0000_0001, 32'h0000_0002, 32'h0, 3, 16'h0000, 49'h0, 1'b1};
        vecs[4]  = '{32'h1000_0003, 32'h0, 32'h0, 32'h0, 1, 16'h0000, 49'h0, 1'b1};
        vecs[5]  = '{32'h1000_0005, 32'hDEAD_BEEF, 32'h0, 32'h0, 2, 16'h0000, 49'h0, 1'b1};
        vecs[6]  = '{32'h7000_0001, 32'h0, 32'h0, 32'h0, 1, 16'h0000, 49'h0, 1'b1};
        vecs[7]  = '{32'h2000_0010, 32'h0, 32'h0, 32'h0, 1, 16'h0000, 49'h0, 1'b1};
        vecs[8]  = '{32'h2000_0007, 32'h0, 32'h0, 32'h0, 1, 16'h0080, 49'h0, 1'b0};
        vecs[9]  = '{32'h1000_0001, 32'h0000_00FF, 32'hFFFE_0000, 32'h0, 3, 16'h0002, 49'h0_0000_0000_00FF, 1'b0};
        vecs[10] = '{32'h2000_0004, 32'h0000_0001, 32'h0000_0002, 32'h0, 3, 16'h0000, 49'h0, 1'b1};
        vecs[11] = '{32'h1000_0002, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4, 16'h0000, 49'h0, 1'b1};
        vecs[12] = '{32'h0000_0003, 32'h0, 32'h0, 32'h0, 1, 16'h0000, 49'h0, 1'b1};
        n_vec = 13;
`ifndef TYPE_RULE_SHADOW_EN
        vecs[13] = '{32'h4000_0002, 32'h0, 32'h0, 32'h0, 1, 16'h0000, 49'h0, 1'b1};
        n_vec = 14;
`endif

        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_data = '0;
        cfg_last = 1'b0;
`ifdef TYPE_RULE_SHADOW_EN
        rd_ready = 1'b0;
`endif
        idle(3);
        rst = 1'b0;
        check("rst_ready", cfg_ready, 1);
        check("rst_wren", rule_wren, 0);
        check("rst_rule", type_rule, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);

        for (int i = 0; i < n_vec; i++) begin
            vw[0] = vecs[i].w0; vw[1] = vecs[i].w1; vw[2] = vecs[i].w2; vw[3] = vecs[i].w3;
            wp0 = wren_pulses;
            ep0 = err_pulses;
            for (int k = 0; k < vecs[i].n; k++)
                send_word(vw[k], (k == vecs[i].n - 1), acc_cyc);
            check($sformatf("v%0d_wren", i), rule_wren, vecs[i].exp_wren);
            check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            if (vecs[i].exp_wren != 0) check($sformatf("v%0d_rule", i), type_rule, vecs[i].exp_rule);
            idle(3);
            #1;
            check($sformatf("v%0d_wren_count", i), wren_pulses - wp0, (vecs[i].exp_wren != 0) ? 1 : 0);
            check($sformatf("v%0d_err_count", i), err_pulses - ep0, vecs[i].exp_err);
            if (vecs[i].exp_wren != 0) check($sformatf("v%0d_rule_held", i), type_rule, vecs[i].exp_rule);
            $display("[TB] vec %0d hdr=%08h words=%0d wren=%04h err=%0b acc_cyc=%0d",
                     i, vecs[i].w0, vecs[i].n, vecs[i].exp_wren, vecs[i].exp_err, acc_cyc);
            @(negedge clk);
        end

        // Back-to-back WRITEs: header spacing and busy flag
        send_word(32'h1000_0004, 1'b0, a0);
        check("b2b_busy", busy, 1);
        send_word(32'h4444_0000, 1'b0, acc_cyc);
        send_word(32'h0000_0004, 1'b1, acc_cyc);
        send_word(32'h1000_0005, 1'b0, a1);
        send_word(32'h5555_0000, 1'b0, acc_cyc);
        send_word(32'h0000_0005, 1'b1, acc_cyc);
        check("b2b_spacing", a1 - a0, 4);
        check("b2b_wren", rule_wren, 16'h0020);
        check("b2b_rule", type_rule, 49'h0_0005_5555_0000);
        $display("[TB] b2b write idx4/idx5 header spacing=%0d cycles", a1 - a0);
        idle(2);

        // CLRALL sweep
        send_word(32'h3000_0000, 1'b1, acc_cyc);
        low = 0;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            exp_oh = 16'h1 << k;
            if (rule_wren !== exp_oh) bad++;
            if (cfg_ready !== 1'b1) low++;
            @(negedge clk);
        end
        guard = 0;
        while (cfg_ready !== 1'b1 && guard < 10) begin
            low++;
            guard++;
            @(negedge clk);
        end
        check("clrall_walk", bad, 0);
        check("clrall_ready_low", low, 17);
        check("clrall_rule", type_rule, 0);
        $display("[TB] clrall ready-low cycles=%0d walk errors=%0d", low, bad);
        idle(2);

        // Reset in the middle of a WRITE
        send_word(32'h1000_0006, 1'b0, acc_cyc);
        send_word(32'h7777_7777, 1'b0, acc_cyc);
        wp0 = wren_pulses;
        ep0 = err_pulses;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_ready", cfg_ready, 1);
        check("midrst_rule", type_rule, 0);
        idle(3);
        #1;
        check("midrst_no_wren", wren_pulses - wp0, 0);
        check("midrst_no_err", err_pulses - ep0, 0);
        @(negedge clk);
        send_word(32'h1000_0001, 1'b0, acc_cyc);
        send_word(32'hCAFE_0001, 1'b0, acc_cyc);
        send_word(32'h0000_0003, 1'b1, acc_cyc);
        check("postrst_wren", rule_wren, 16'h0002);
        check("postrst_rule", type_rule, 49'h0_0003_CAFE_0001);
        $display("[TB] reset mid-command then write idx1 wren=%04h", rule_wren);
        idle(2);

`ifdef TYPE_RULE_SHADOW_EN
        // Shadow read-back with a toggling consumer
        send_word(32'h1000_0002, 1'b0, acc_cyc);
        send_word(32'h1111_2222, 1'b0, acc_cyc);
        send_word(32'h0001_3333, 1'b1, acc_cyc);
        idle(2);
        send_word(32'h4000_0002, 1'b1, acc_cyc);
        begin
            logic [31:0] got [2];
            logic        got_last [2];
            int          n_got;
            n_got = 0;
            guard = 0;
            while (n_got < 2 && guard < 40) begin
                rd_ready = ~rd_ready;
                if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                    got[n_got] = rd_data;
                    got_last[n_got] = rd_last;
                    n_got++;
                end else if (rd_valid === 1'b1) begin
                    check("rd_hold", rd_data, (n_got == 0) ? 32'h1111_2222 : 32'h0001_3333);
                end
                @(negedge clk);
                guard++;
            end
            rd_ready = 1'b0;
            check("rd_count", n_got, 2);
            if (n_got == 2) begin
                check("rd_word0", got[0], 32'h1111_2222);
                check("rd_word1", got[1], 32'h0001_3333);
                check("rd_last0", got_last[0], 0);
                check("rd_last1", got_last[1], 1);
            end
            idle(1);
            check("rd_ready_back", cfg_ready, 1);
            $display("[TB] shadow read idx2 words=%0d", n_got);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
